// File: rtl/spu_issue_if.sv
// Decode-to-issue handshake plus the per-pipe operand bus driven by the issue stage.
// The master side is decode (and the pipe consumer); the slave side is spu_issue_stage.
interface spu_issue_if #(
  parameter int unsigned OPCODE_LEN = 11,
  parameter int unsigned LAT_WD     = 3
);
  logic                  in_valid;
  logic                  in_ready;

  logic                  i0_valid;
  logic [OPCODE_LEN-1:0] i0_opcode;
  logic                  i0_pipe;
  logic [6:0]            i0_ra, i0_rb, i0_rc, i0_rt;
  logic [2:0]            i0_use;
  logic                  i0_wr;
  logic [LAT_WD-1:0]     i0_lat;
  logic [17:0]           i0_imm;

  logic                  i1_valid;
  logic [OPCODE_LEN-1:0] i1_opcode;
  logic                  i1_pipe;
  logic [6:0]            i1_ra, i1_rb, i1_rc, i1_rt;
  logic [2:0]            i1_use;
  logic                  i1_wr;
  logic [LAT_WD-1:0]     i1_lat;
  logic [17:0]           i1_imm;

  logic [OPCODE_LEN-1:0] opcode_ep, opcode_op;
  logic [6:0]            ra_addr_ep, rb_addr_ep, rc_addr_ep, rt_addr_ep;
  logic [6:0]            ra_addr_op, rb_addr_op, rc_addr_op, rt_addr_op;
  logic [6:0]            in_I7e, in_I7o;
  logic [7:0]            in_I8e, in_I8o;
  logic [9:0]            in_I10e, in_I10o;
  logic [15:0]           in_I16e, in_I16o;
  logic [17:0]           in_I18e, in_I18o;

  modport master (
    output in_valid,
    output i0_valid, i0_opcode, i0_pipe, i0_ra, i0_rb, i0_rc, i0_rt, i0_use, i0_wr, i0_lat,
    output i0_imm,
    output i1_valid, i1_opcode, i1_pipe, i1_ra, i1_rb, i1_rc, i1_rt, i1_use, i1_wr, i1_lat,
    output i1_imm,
    input  in_ready,
    input  opcode_ep, opcode_op,
    input  ra_addr_ep, rb_addr_ep, rc_addr_ep, rt_addr_ep,
    input  ra_addr_op, rb_addr_op, rc_addr_op, rt_addr_op,
    input  in_I7e, in_I8e, in_I10e, in_I16e, in_I18e,
    input  in_I7o, in_I8o, in_I10o, in_I16o, in_I18o
  );

  modport slave (
    input  in_valid,
    input  i0_valid, i0_opcode, i0_pipe, i0_ra, i0_rb, i0_rc, i0_rt, i0_use, i0_wr, i0_lat,
    input  i0_imm,
    input  i1_valid, i1_opcode, i1_pipe, i1_ra, i1_rb, i1_rc, i1_rt, i1_use, i1_wr, i1_lat,
    input  i1_imm,
    output in_ready,
    output opcode_ep, opcode_op,
    output ra_addr_ep, rb_addr_ep, rc_addr_ep, rt_addr_ep,
    output ra_addr_op, rb_addr_op, rc_addr_op, rt_addr_op,
    output in_I7e, in_I8e, in_I10e, in_I16e, in_I18e,
    output in_I7o, in_I8o, in_I10o, in_I16o, in_I18o
  );
endinterface

// File: rtl/spu_issue_stage.sv
// Dual-issue stage: buffers an in-order pair, routes each slot to the even/odd pipe and holds
// on structural, RAW or intra-pair WAW hazards, tracking in-flight writes with a countdown table.
module spu_issue_stage #(
  parameter int unsigned           OPCODE_LEN = 11,
  parameter logic [OPCODE_LEN-1:0] NOP_OPCODE = '0,
  parameter int unsigned           NUM_REGS   = 128,
  parameter int unsigned           LAT_WD     = 3
) (
  input logic        clk,
  input logic        rst,
  input logic        flush,
  spu_issue_if.slave bus
);

  typedef struct packed {
    logic [OPCODE_LEN-1:0] opcode;
    logic                  pipe;
    logic [6:0]            ra;
    logic [6:0]            rb;
    logic [6:0]            rc;
    logic [6:0]            rt;
    logic [2:0]            rd_use;
    logic                  wr;
    logic [LAT_WD-1:0]     lat;
    logic [17:0]           imm;
  } slot_t;

  typedef struct packed {
    logic [OPCODE_LEN-1:0] opcode;
    logic [6:0]            ra;
    logic [6:0]            rb;
    logic [6:0]            rc;
    logic [6:0]            rt;
    logic [17:0]           imm;
  } out_t;

  localparam out_t NopOut = '{opcode: NOP_OPCODE, ra: '0, rb: '0, rc: '0, rt: '0, imm: '0};

  // A source is ready once its producer is at most one cycle from forwarding.
  function automatic logic src_ok(input logic [2:0] rd_use, input logic [LAT_WD-1:0] sa,
                                  input logic [LAT_WD-1:0] sbv, input logic [LAT_WD-1:0] sc);
    return !((rd_use[0] && (sa > LAT_WD'(1))) || (rd_use[1] && (sbv > LAT_WD'(1))) ||
             (rd_use[2] && (sc > LAT_WD'(1))));
  endfunction

  function automatic out_t to_out(input slot_t s);
    out_t o;
    o.opcode = s.opcode;
    o.ra     = s.ra;
    o.rb     = s.rb;
    o.rc     = s.rc;
    o.rt     = s.rt;
    o.imm    = s.imm;
    return o;
  endfunction

  logic              v0_q, v0_d, v1_q, v1_d;
  slot_t             s0_q, s0_d, s1_q, s1_d;
  slot_t             in0, in1;
  logic [LAT_WD-1:0] sb_q [NUM_REGS];
  logic [LAT_WD-1:0] sb_d [NUM_REGS];
  out_t              ep_q, ep_d, op_q, op_d;

  slot_t a, b;
  logic  a_valid, b_valid, a_ok, b_ok, b_raw, b_waw;
  logic  issue_a, issue_b, issue0, issue1;
  logic  in_ready, accept;

  always_comb begin
    in0.opcode = bus.i0_opcode;
    in0.pipe   = bus.i0_pipe;
    in0.ra     = bus.i0_ra;
    in0.rb     = bus.i0_rb;
    in0.rc     = bus.i0_rc;
    in0.rt     = bus.i0_rt;
    in0.rd_use = bus.i0_use;
    in0.wr     = bus.i0_wr;
    in0.lat    = bus.i0_lat;
    in0.imm    = bus.i0_imm;
    in1.opcode = bus.i1_opcode;
    in1.pipe   = bus.i1_pipe;
    in1.ra     = bus.i1_ra;
    in1.rb     = bus.i1_rb;
    in1.rc     = bus.i1_rc;
    in1.rt     = bus.i1_rt;
    in1.rd_use = bus.i1_use;
    in1.wr     = bus.i1_wr;
    in1.lat    = bus.i1_lat;
    in1.imm    = bus.i1_imm;
  end

  // Issue decision: A is the oldest valid slot, B exists only when both slots are valid.
  always_comb begin
    a       = v0_q ? s0_q : s1_q;
    b       = s1_q;
    a_valid = v0_q | v1_q;
    b_valid = v0_q & v1_q;
    a_ok    = src_ok(a.rd_use, sb_q[a.ra], sb_q[a.rb], sb_q[a.rc]);
    b_ok    = src_ok(b.rd_use, sb_q[b.ra], sb_q[b.rb], sb_q[b.rc]);
    b_raw   = a.wr & ((b.rd_use[0] & (b.ra == a.rt)) | (b.rd_use[1] & (b.rb == a.rt)) |
                      (b.rd_use[2] & (b.rc == a.rt)));
    b_waw   = a.wr & b.wr & (a.rt == b.rt);
    issue_a = a_valid & a_ok & ~flush;
    issue_b = b_valid & issue_a & (a.pipe != b.pipe) & b_ok & ~b_raw & ~b_waw;
    issue0  = v0_q & issue_a;
    issue1  = v0_q ? issue_b : (v1_q & issue_a);
    in_ready = (~v0_q | issue0) & (~v1_q | issue1);
    accept  = bus.in_valid & in_ready & ~flush;
  end

  always_comb begin
    v0_d = v0_q & ~issue0;
    v1_d = v1_q & ~issue1;
    s0_d = s0_q;
    s1_d = s1_q;
    if (flush) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
    end else if (accept) begin
      v0_d = bus.i0_valid;
      v1_d = bus.i1_valid;
      s0_d = in0;
      s1_d = in1;
    end
  end

  // Countdown per destination; a fresh issue overrides the decrement.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      sb_d[i] = (sb_q[i] != '0) ? sb_q[i] - LAT_WD'(1) : '0;
    end
    if (issue_a && a.wr && (a.lat != '0)) sb_d[a.rt] = a.lat;
    if (issue_b && b.wr && (b.lat != '0)) sb_d[b.rt] = b.lat;
  end

  always_comb begin
    ep_d = NopOut;
    op_d = NopOut;
    if (issue_a && !a.pipe)      ep_d = to_out(a);
    else if (issue_b && !b.pipe) ep_d = to_out(b);
    if (issue_a && a.pipe)       op_d = to_out(a);
    else if (issue_b && b.pipe)  op_d = to_out(b);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      s0_q <= '0;
      s1_q <= '0;
      ep_q <= NopOut;
      op_q <= NopOut;
      for (int i = 0; i < NUM_REGS; i++) sb_q[i] <= '0;
    end else begin
      v0_q <= v0_d;
      v1_q <= v1_d;
      s0_q <= s0_d;
      s1_q <= s1_d;
      ep_q <= ep_d;
      op_q <= op_d;
      for (int i = 0; i < NUM_REGS; i++) sb_q[i] <= sb_d[i];
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.opcode_ep  = ep_q.opcode;
  assign bus.ra_addr_ep = ep_q.ra;
  assign bus.rb_addr_ep = ep_q.rb;
  assign bus.rc_addr_ep = ep_q.rc;
  assign bus.rt_addr_ep = ep_q.rt;
  assign bus.in_I7e     = ep_q.imm[6:0];
  assign bus.in_I8e     = ep_q.imm[7:0];
  assign bus.in_I10e    = ep_q.imm[9:0];
  assign bus.in_I16e    = ep_q.imm[15:0];
  assign bus.in_I18e    = ep_q.imm;
  assign bus.opcode_op  = op_q.opcode;
  assign bus.ra_addr_op = op_q.ra;
  assign bus.rb_addr_op = op_q.rb;
  assign bus.rc_addr_op = op_q.rc;
  assign bus.rt_addr_op = op_q.rt;
  assign bus.in_I7o     = op_q.imm[6:0];
  assign bus.in_I8o     = op_q.imm[7:0];
  assign bus.in_I10o    = op_q.imm[9:0];
  assign bus.in_I16o    = op_q.imm[15:0];
  assign bus.in_I18o    = op_q.imm;

endmodule

// File: tb/tb_spu_issue_stage.sv
// Directed bench for spu_issue_stage: stimulus pushes expected pipe outputs into per-pipe
// queues with the cycle they must appear; a negedge monitor pops and compares.
module tb_spu_issue_stage;
  localparam logic [10:0] NOP = 11'h000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spu_issue_if #(.OPCODE_LEN(11), .LAT_WD(3)) bus ();

  spu_issue_stage #(
    .OPCODE_LEN(11),
    .NOP_OPCODE(NOP),
    .NUM_REGS  (128),
    .LAT_WD    (3)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  typedef struct {
    bit          v;
    logic [10:0] op;
    bit          pipe;
    logic [6:0]  ra, rb, rc, rt;
    logic [2:0]  usef;
    bit          wr;
    logic [2:0]  lat;
    logic [17:0] imm;
  } slot_t;

  typedef struct {
    int          cyc;
    logic [10:0] op;
    logic [6:0]  ra, rb, rc, rt;
    logic [17:0] imm;
  } exp_t;

  exp_t q_e[$];
  exp_t q_o[$];

  function automatic slot_t mk(input logic [10:0] op, input bit pipe, input logic [6:0] ra,
                               input logic [6:0] rb, input logic [6:0] rc, input logic [6:0] rt,
                               input logic [2:0] usef, input bit wr, input logic [2:0] lat,
                               input logic [17:0] imm);
    slot_t s;
    s.v = 1'b1; s.op = op; s.pipe = pipe; s.ra = ra; s.rb = rb; s.rc = rc; s.rt = rt;
    s.usef = usef; s.wr = wr; s.lat = lat; s.imm = imm;
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic bit outs_zero();
    return (bus.opcode_ep == NOP) && (bus.opcode_op == NOP) &&
           ({bus.ra_addr_ep, bus.rb_addr_ep, bus.rc_addr_ep, bus.rt_addr_ep} == '0) &&
           ({bus.ra_addr_op, bus.rb_addr_op, bus.rc_addr_op, bus.rt_addr_op} == '0) &&
           ({bus.in_I7e, bus.in_I8e, bus.in_I10e, bus.in_I16e, bus.in_I18e} == '0) &&
           ({bus.in_I7o, bus.in_I8o, bus.in_I10o, bus.in_I16o, bus.in_I18o} == '0);
  endfunction

  task automatic push(input slot_t s, input int c);
    exp_t e;
    e.cyc = c; e.op = s.op; e.ra = s.ra; e.rb = s.rb; e.rc = s.rc; e.rt = s.rt; e.imm = s.imm;
    if (s.pipe) q_o.push_back(e);
    else q_e.push_back(e);
  endtask

  task automatic drive(input slot_t s0, input slot_t s1);
    bus.i0_valid = s0.v; bus.i0_opcode = s0.op; bus.i0_pipe = s0.pipe;
    bus.i0_ra = s0.ra; bus.i0_rb = s0.rb; bus.i0_rc = s0.rc; bus.i0_rt = s0.rt;
    bus.i0_use = s0.usef; bus.i0_wr = s0.wr; bus.i0_lat = s0.lat; bus.i0_imm = s0.imm;
    bus.i1_valid = s1.v; bus.i1_opcode = s1.op; bus.i1_pipe = s1.pipe;
    bus.i1_ra = s1.ra; bus.i1_rb = s1.rb; bus.i1_rc = s1.rc; bus.i1_rt = s1.rt;
    bus.i1_use = s1.usef; bus.i1_wr = s1.wr; bus.i1_lat = s1.lat; bus.i1_imm = s1.imm;
  endtask

  // Called just after a posedge; returns the first decision cycle of the accepted pair.
  task automatic send(input slot_t s0, input slot_t s1, output int n);
    int budget = 50;
    drive(s0, s1);
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) chk("accept_timeout", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.i0_valid = 1'b0;
    bus.i1_valid = 1'b0;
    n = cyc;
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic mon_pipe(input bit pipe, input logic [10:0] op, input logic [6:0] ra,
                          input logic [6:0] rb, input logic [6:0] rc, input logic [6:0] rt,
                          input logic [6:0] i7, input logic [7:0] i8, input logic [9:0] i10,
                          input logic [15:0] i16, input logic [17:0] i18);
    exp_t  e;
    string p = pipe ? "odd" : "even";
    if (op == NOP) begin
      chk({p, "_nop_zero"}, 64'(|{ra, rb, rc, rt, i7, i8, i10, i16, i18}), 64'd0);
    end else if ((pipe ? q_o.size() : q_e.size()) == 0) begin
      chk({p, "_unexpected_issue"}, 64'(op), 64'(NOP));
    end else begin
      if (pipe) e = q_o.pop_front();
      else e = q_e.pop_front();
      chk({p, "_issue_cycle"}, 64'(cyc), 64'(e.cyc));
      chk({p, "_fields"}, 64'({op, ra, rb, rc, rt, i18}),
          64'({e.op, e.ra, e.rb, e.rc, e.rt, e.imm}));
      chk({p, "_imm_slices"}, 64'({i7, i8, i10, i16}),
          64'({e.imm[6:0], e.imm[7:0], e.imm[9:0], e.imm[15:0]}));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_pipe(1'b0, bus.opcode_ep, bus.ra_addr_ep, bus.rb_addr_ep, bus.rc_addr_ep,
               bus.rt_addr_ep, bus.in_I7e, bus.in_I8e, bus.in_I10e, bus.in_I16e, bus.in_I18e);
      mon_pipe(1'b1, bus.opcode_op, bus.ra_addr_op, bus.rb_addr_op, bus.rc_addr_op,
               bus.rt_addr_op, bus.in_I7o, bus.in_I8o, bus.in_I10o, bus.in_I16o, bus.in_I18o);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, actual running required finished");
    $fatal(1);
  end

  initial begin
    slot_t nil, a, b, c;
    int n, m, k;
    nil = mk(11'h0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0, 3'd0, 18'h0);
    nil.v = 1'b0;
    drive(nil, nil);
    bus.in_valid = 1'b0;

    #2;
    chk("reset_outputs_nop", 64'(outs_zero()), 64'd1);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    idle(1);

    // Independent even/odd pair issues together.
    a = mk(11'h0A1, 1'b0, 7'd1, 7'd2, 7'd0, 7'd3, 3'b011, 1'b1, 3'd2, 18'h2ABCD);
    b = mk(11'h1B2, 1'b1, 7'd10, 7'd11, 7'd0, 7'd4, 3'b011, 1'b1, 3'd4, 18'h15555);
    send(a, b, n);
    push(a, n + 1);
    push(b, n + 1);
    @(negedge clk);
    chk("t1_in_ready", 64'(bus.in_ready), 64'd1);
    idle(4);

    // Two even instructions: one per cycle, in order.
    a = mk(11'h021, 1'b0, 7'd12, 7'd0, 7'd0, 7'd13, 3'b001, 1'b1, 3'd1, 18'h00123);
    b = mk(11'h022, 1'b0, 7'd14, 7'd0, 7'd0, 7'd15, 3'b001, 1'b1, 3'd1, 18'h3FFFF);
    send(a, b, n);
    push(a, n + 1);
    push(b, n + 2);
    @(negedge clk);
    chk("t2_in_ready", 64'(bus.in_ready), 64'd0);
    idle(4);

    // Long-latency producer; consumer arrives as slot1-only pair and waits six cycles.
    a = mk(11'h031, 1'b0, 7'd0, 7'd0, 7'd0, 7'd5, 3'b000, 1'b1, 3'd6, 18'h00031);
    send(a, nil, n);
    push(a, n + 1);
    b = mk(11'h032, 1'b1, 7'd5, 7'd0, 7'd0, 7'd16, 3'b001, 1'b1, 3'd1, 18'h00032);
    send(nil, b, m);
    push(b, n + 7);
    @(negedge clk);
    chk("t3_stall_in_ready", 64'(bus.in_ready), 64'd0);
    idle(10);

    // Intra-pair RAW: slot1 follows one cycle later.
    a = mk(11'h041, 1'b0, 7'd0, 7'd0, 7'd0, 7'd9, 3'b000, 1'b1, 3'd1, 18'h00041);
    b = mk(11'h042, 1'b1, 7'd9, 7'd0, 7'd0, 7'd17, 3'b001, 1'b1, 3'd1, 18'h00042);
    send(a, b, n);
    push(a, n + 1);
    push(b, n + 2);
    idle(5);

    // Intra-pair WAW on r7; no scoreboard WAW hold afterwards.
    a = mk(11'h051, 1'b0, 7'd0, 7'd0, 7'd0, 7'd7, 3'b000, 1'b1, 3'd2, 18'h00051);
    b = mk(11'h052, 1'b1, 7'd0, 7'd0, 7'd0, 7'd7, 3'b000, 1'b1, 3'd3, 18'h00052);
    send(a, b, n);
    push(a, n + 1);
    push(b, n + 2);
    idle(8);

    // Flush during a RAW stall; the scoreboard survives the flush.
    a = mk(11'h061, 1'b0, 7'd0, 7'd0, 7'd0, 7'd5, 3'b000, 1'b1, 3'd7, 18'h00061);
    send(a, nil, n);
    push(a, n + 1);
    b = mk(11'h062, 1'b1, 7'd5, 7'd0, 7'd0, 7'd18, 3'b001, 1'b1, 3'd1, 18'h00062);
    c = mk(11'h063, 1'b0, 7'd19, 7'd0, 7'd0, 7'd0, 3'b001, 1'b0, 3'd0, 18'h00063);
    send(b, c, m);
    idle(2);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    a = mk(11'h064, 1'b0, 7'd5, 7'd0, 7'd0, 7'd0, 3'b001, 1'b0, 3'd0, 18'h00064);
    b = mk(11'h065, 1'b1, 7'd21, 7'd0, 7'd0, 7'd0, 3'b001, 1'b0, 3'd0, 18'h00065);
    send(a, b, k);
    chk("t6_accept_after_flush", 64'(k), 64'(n + 5));
    push(a, n + 8);
    push(b, n + 8);
    idle(8);

    // Asynchronous reset mid-stall clears outputs, buffer and scoreboard.
    a = mk(11'h071, 1'b0, 7'd0, 7'd0, 7'd0, 7'd20, 3'b000, 1'b1, 3'd7, 18'h00071);
    send(a, nil, n);
    push(a, n + 1);
    b = mk(11'h072, 1'b0, 7'd20, 7'd0, 7'd0, 7'd0, 3'b001, 1'b0, 3'd0, 18'h00072);
    send(b, nil, m);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t7_rst_outputs_nop", 64'(outs_zero()), 64'd1);
    chk("t7_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    idle(1);
    c = mk(11'h073, 1'b1, 7'd20, 7'd0, 7'd0, 7'd0, 3'b001, 1'b0, 3'd0, 18'h00073);
    send(c, nil, k);
    push(c, k + 1);
    idle(10);

    chk("even_queue_drained", 64'(q_e.size()), 64'd0);
    chk("odd_queue_drained", 64'(q_o.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
